// File: rtl/w_mem_pkg.sv
// Shared geometry helpers and default constants for the banked weight-memory controller.
// Optional build macro used by the top level: W_MEM_ACCESS_CNT_EN (per-bank access counters).
package w_mem_pkg;

    localparam int DEF_N_COLS     = 4;
    localparam int DEF_WORD_BITS  = 8;
    localparam int DEF_N_BANKS    = 2;
    localparam int DEF_BANK_DEPTH = 1024;
    localparam int DEF_RD_PIPE    = 0;
    localparam int RD_PIPE_MIN    = 0;
    localparam int RD_PIPE_MAX    = 1;

    // Bank field disappears from the address when there is a single bank.
    function automatic int bank_w(input int n_banks);
        return (n_banks > 1) ? $clog2(n_banks) : 0;
    endfunction

    function automatic int row_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int col_w(input int n_cols);
        return $clog2(n_cols);
    endfunction

    // Width of the internal bank index register; never zero.
    function automatic int idx_w(input int n_banks);
        return (bank_w(n_banks) > 0) ? bank_w(n_banks) : 1;
    endfunction

endpackage

// File: rtl/w_mem_bank.sv
// Behavioural single-port SRAM bank: one row of N_COLS words per access, active-low CEB/WEB/BWEB.
// Scan mode parks the array (no read or write takes effect).
module w_mem_bank
    import w_mem_pkg::*;
#(
    parameter int  N_COLS    = DEF_N_COLS,
    parameter int  WORD_BITS = DEF_WORD_BITS,
    parameter int  DEPTH     = DEF_BANK_DEPTH,
    localparam int ROW_W     = row_w(DEPTH),
    localparam int ROW_BITS  = N_COLS * WORD_BITS
) (
    input  logic                clk,
    input  logic                scan_en_in,
    input  logic                ceb,
    input  logic                web,
    input  logic [N_COLS-1:0]   bweb,
    input  logic [ROW_W-1:0]    a,
    input  logic [ROW_BITS-1:0] d,
    output logic [ROW_BITS-1:0] q
);

    logic [ROW_BITS-1:0] mem_r [DEPTH];
    logic [ROW_BITS-1:0] q_r;

    // Array access: masked row write, or row read into the output latch.
    always_ff @(posedge clk) begin
        if (!ceb && !scan_en_in) begin
            if (!web) begin
                for (int i = 0; i < N_COLS; i++) begin
                    if (!bweb[i]) begin
                        mem_r[a][i*WORD_BITS +: WORD_BITS] <= d[i*WORD_BITS +: WORD_BITS];
                    end
                end
            end else begin
                q_r <= mem_r[a];
            end
        end
    end

    assign q = q_r;

endmodule

// File: rtl/w_mem_banked_sram_ctrl.sv
// Banked weight-memory controller: write/read channels, same-bank arbitration, pipelined read return.
// Build macro W_MEM_ACCESS_CNT_EN adds per-bank saturating read/write counters with cnt_clr.
module w_mem_banked_sram_ctrl
    import w_mem_pkg::*;
#(
    parameter int  N_COLS     = DEF_N_COLS,
    parameter int  WORD_BITS  = DEF_WORD_BITS,
    parameter int  N_BANKS    = DEF_N_BANKS,
    parameter int  BANK_DEPTH = DEF_BANK_DEPTH,
    parameter int  RD_PIPE    = DEF_RD_PIPE,
    localparam int BANK_W     = bank_w(N_BANKS),
    localparam int ROW_W      = row_w(BANK_DEPTH),
    localparam int COL_W      = col_w(N_COLS),
    localparam int ADDR_W     = BANK_W + ROW_W + COL_W,
    localparam int ROW_BITS   = N_COLS * WORD_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scan_en_in,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [ROW_BITS-1:0]   wr_data,
    input  logic [N_COLS-1:0]     wr_strb,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic                  rsp_valid,
    output logic [ROW_BITS-1:0]   rsp_data,
`ifdef W_MEM_ACCESS_CNT_EN
    input  logic                  cnt_clr,
    output logic [N_BANKS*32-1:0] rd_cnt,
    output logic [N_BANKS*32-1:0] wr_cnt,
`endif
    output logic                  err_oob
);

    localparam int IDX_W = idx_w(N_BANKS);

    logic [IDX_W-1:0]    wr_bank_s, rd_bank_s;
    logic [ROW_W-1:0]    wr_row_s, rd_row_s;
    logic                wr_oob_s, rd_oob_s;
    logic                wr_acc_s, rd_acc_s;
    logic                rd_vld_r, rd_oob_r, err_oob_r;
    logic [IDX_W-1:0]    rd_bank_r;
    logic [ROW_BITS-1:0] rd_mux_s;
    logic                rsp_vld_pre_s, rsp_vld_s;
    logic [ROW_BITS-1:0] bank_q_s [N_BANKS];

    assign wr_row_s = wr_addr[COL_W +: ROW_W];
    assign rd_row_s = rd_addr[COL_W +: ROW_W];

    if (BANK_W > 0) begin : g_bank_field
        assign wr_bank_s = wr_addr[ADDR_W-1 -: BANK_W];
        assign rd_bank_s = rd_addr[ADDR_W-1 -: BANK_W];
    end else begin : g_single_bank
        assign wr_bank_s = '0;
        assign rd_bank_s = '0;
    end

    if (COL_W > 0) begin : g_col_sink
        logic unused_col_s;
        assign unused_col_s = ^{wr_addr[COL_W-1:0], rd_addr[COL_W-1:0]};
    end

    assign wr_oob_s = (32'(wr_bank_s) >= 32'(N_BANKS));
    assign rd_oob_s = (32'(rd_bank_s) >= 32'(N_BANKS));

    // Writes always win a same-bank collision; requests seen while in reset are ignored.
    assign wr_ready = 1'b1;
    assign rd_ready = !(wr_valid && rd_valid && (wr_bank_s == rd_bank_s));
    assign wr_acc_s = wr_valid && reset;
    assign rd_acc_s = rd_valid && rd_ready && reset;

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        logic                ceb_s, web_s;
        logic [N_COLS-1:0]   bweb_s;
        logic [ROW_W-1:0]    a_s;
        logic [ROW_BITS-1:0] d_s;

        // Steer the accepted write or read to this bank; both cannot target it in one cycle.
        always_comb begin
            ceb_s  = 1'b1;
            web_s  = 1'b1;
            bweb_s = '1;
            a_s    = '0;
            d_s    = '0;
            if (wr_acc_s && !wr_oob_s && (wr_bank_s == IDX_W'(b)) && (wr_strb != '0)) begin
                ceb_s  = 1'b0;
                web_s  = 1'b0;
                bweb_s = ~wr_strb;
                a_s    = wr_row_s;
                d_s    = wr_data;
            end else if (rd_acc_s && !rd_oob_s && (rd_bank_s == IDX_W'(b))) begin
                ceb_s  = 1'b0;
                web_s  = 1'b1;
                a_s    = rd_row_s;
            end else begin
                ceb_s  = 1'b1;
            end
        end

        w_mem_bank #(
            .N_COLS    (N_COLS),
            .WORD_BITS (WORD_BITS),
            .DEPTH     (BANK_DEPTH)
        ) u_bank (
            .clk        (clk),
            .scan_en_in (scan_en_in),
            .ceb        (ceb_s),
            .web        (web_s),
            .bweb       (bweb_s),
            .a          (a_s),
            .d          (d_s),
            .q          (bank_q_s[b])
        );
    end

    // Read stage 1: valid, bank index and range flag travel with the SRAM access.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_vld_r  <= 1'b0;
            rd_bank_r <= '0;
            rd_oob_r  <= 1'b0;
            err_oob_r <= 1'b0;
        end else begin
            rd_vld_r  <= rd_acc_s;
            err_oob_r <= (wr_acc_s && wr_oob_s) || (rd_acc_s && rd_oob_s);
            if (rd_acc_s) begin
                rd_bank_r <= rd_bank_s;
                rd_oob_r  <= rd_oob_s;
            end
        end
    end

    // Select the bank captured at accept time; an out-of-range read returns zero.
    always_comb begin
        rd_mux_s = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            rd_mux_s = rd_mux_s | ((!rd_oob_r && (rd_bank_r == IDX_W'(b))) ? bank_q_s[b] : '0);
        end
    end

    if (RD_PIPE == 0) begin : g_rd_direct
        logic [ROW_BITS-1:0] hold_r;

        // Keep the last delivered row so rsp_data is stable between responses.
        always_ff @(posedge clk) begin
            if (!reset) begin
                hold_r <= '0;
            end else if (rsp_vld_s) begin
                hold_r <= rd_mux_s;
            end
        end

        assign rsp_vld_pre_s = rd_vld_r;
        assign rsp_data      = rsp_vld_s ? rd_mux_s : hold_r;
    end else begin : g_rd_piped
        logic                vld2_r;
        logic [ROW_BITS-1:0] data2_r;

        // Extra output register stage on the read return.
        always_ff @(posedge clk) begin
            if (!reset) begin
                vld2_r  <= 1'b0;
                data2_r <= '0;
            end else begin
                vld2_r <= rd_vld_r;
                if (rd_vld_r) begin
                    data2_r <= rd_mux_s;
                end
            end
        end

        assign rsp_vld_pre_s = vld2_r;
        assign rsp_data      = data2_r;
    end

    // A read still in flight when reset arrives never surfaces as a response.
    assign rsp_vld_s = rsp_vld_pre_s && reset;
    assign rsp_valid = rsp_vld_s;
    assign err_oob   = err_oob_r;

`ifdef W_MEM_ACCESS_CNT_EN
    for (genvar b = 0; b < N_BANKS; b++) begin : g_cnt
        logic [31:0] rd_cnt_r, wr_cnt_r;
        logic        rd_hit_s, wr_hit_s;

        assign rd_hit_s = rd_acc_s && !rd_oob_s && (rd_bank_s == IDX_W'(b));
        assign wr_hit_s = wr_acc_s && !wr_oob_s && (wr_bank_s == IDX_W'(b));

        // Saturating per-bank access counters for energy profiling.
        always_ff @(posedge clk) begin
            if (!reset || cnt_clr) begin
                rd_cnt_r <= 32'd0;
                wr_cnt_r <= 32'd0;
            end else begin
                if (rd_hit_s && (rd_cnt_r != 32'hFFFF_FFFF)) begin
                    rd_cnt_r <= rd_cnt_r + 32'd1;
                end
                if (wr_hit_s && (wr_cnt_r != 32'hFFFF_FFFF)) begin
                    wr_cnt_r <= wr_cnt_r + 32'd1;
                end
            end
        end

        assign rd_cnt[b*32 +: 32] = rd_cnt_r;
        assign wr_cnt[b*32 +: 32] = wr_cnt_r;
    end
`endif

endmodule

// File: tb/tb_w_mem_banked_sram_ctrl.sv
// Scoreboard bench for w_mem_banked_sram_ctrl with three banks (bank index 3 is out of range).
// Directed stimulus pushes expected responses; a negedge monitor pops and compares them.
module tb_w_mem_banked_sram_ctrl;

    localparam int N_BANKS = 3;
    localparam int RD_PIPE = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        scan_en_in = 1'b0;
    logic        wr_valid = 1'b0;
    logic        rd_valid = 1'b0;
    logic [13:0] wr_addr = 14'd0;
    logic [13:0] rd_addr = 14'd0;
    logic [31:0] wr_data = 32'd0;
    logic [3:0]  wr_strb = 4'd0;
    logic        wr_ready, rd_ready, rsp_valid, err_oob;
    logic [31:0] rsp_data;
`ifdef W_MEM_ACCESS_CNT_EN
    logic        cnt_clr = 1'b0;
    logic [N_BANKS*32-1:0] rd_cnt, wr_cnt;
`endif

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t rsp_q[$];
    int   oob_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    w_mem_banked_sram_ctrl #(
        .N_COLS     (4),
        .WORD_BITS  (8),
        .N_BANKS    (N_BANKS),
        .BANK_DEPTH (1024),
        .RD_PIPE    (RD_PIPE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_en_in (scan_en_in),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_strb    (wr_strb),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
`ifdef W_MEM_ACCESS_CNT_EN
        .cnt_clr    (cnt_clr),
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt),
`endif
        .err_oob    (err_oob)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [13:0] mk_addr(input int bank, input int row);
        logic [13:0] a;
        a = {bank[1:0], row[9:0], 2'b00};
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pops expected read responses and err_oob pulses, flags late or spurious ones.
    always @(negedge clk) begin
        rsp_t e;
        if (rsp_valid) begin
            checks++;
            if (rsp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected actual=%h expected=none cyc=%0d", rsp_data, cyc);
            end else begin
                e = rsp_q.pop_front();
                if ((rsp_data !== e.data) || (e.due != cyc)) begin
                    failures++;
                    $display("FAIL rsp_data actual=%h@%0d expected=%h@%0d", rsp_data, cyc, e.data, e.due);
                end
            end
        end
        if ((rsp_q.size() > 0) && (rsp_q[0].due < cyc)) begin
            checks++;
            failures++;
            $display("FAIL rsp_missing actual=none expected=%h@%0d", rsp_q[0].data, rsp_q[0].due);
            void'(rsp_q.pop_front());
        end
        if (err_oob) begin
            checks++;
            if ((oob_q.size() == 0) || (oob_q[0] != cyc)) begin
                failures++;
                $display("FAIL err_oob_unexpected actual=1@%0d expected=0", cyc);
            end else begin
                void'(oob_q.pop_front());
            end
        end
        if ((oob_q.size() > 0) && (oob_q[0] < cyc)) begin
            checks++;
            failures++;
            $display("FAIL err_oob_missing actual=0 expected=1@%0d", oob_q[0]);
            void'(oob_q.pop_front());
        end
    end

    // One request cycle; called just after a rising edge, returns just after the next one.
    task automatic step(input logic wv, input logic [13:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                        input logic rv, input logic [13:0] ra, input logic exp_rdy,
                        input logic exp_rsp, input logic [31:0] rexp);
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        wr_strb  = ws;
        rd_valid = rv;
        rd_addr  = ra;
        @(negedge clk);
        if (wv) chk("wr_ready", {31'd0, wr_ready}, 32'd1);
        if (rv) chk("rd_ready", {31'd0, rd_ready}, {31'd0, exp_rdy});
        if (rv && exp_rdy && exp_rsp) rsp_q.push_back('{data: rexp, due: cyc + 1 + RD_PIPE});
        if (wv && (wa[13:12] >= 2'd3)) oob_q.push_back(cyc + 1);
        if (rv && exp_rdy && exp_rsp && (ra[13:12] >= 2'd3)) oob_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 14'd0, 32'd0, 4'd0, 1'b0, 14'd0, 1'b1, 1'b0, 32'd0);
        end
    endtask

    task automatic wr(input int bank, input int row, input logic [31:0] d, input logic [3:0] s);
        step(1'b1, mk_addr(bank, row), d, s, 1'b0, 14'd0, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic rd(input int bank, input int row, input logic [31:0] exp);
        step(1'b0, 14'd0, 32'd0, 4'd0, 1'b1, mk_addr(bank, row), 1'b1, 1'b1, exp);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_err_oob", {31'd0, err_oob}, 32'd0);
        chk("reset_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("reset_rd_ready", {31'd0, rd_ready}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);

        // Full-row write then read-back, followed by hold check
        wr(1, 5, 32'hDEADBEEF, 4'hF);
        rd(1, 5, 32'hDEADBEEF);
        idle(1);
        @(negedge clk);
        chk("hold_rsp_data", rsp_data, 32'hDEADBEEF);
        @(posedge clk);
        #1;

        // Partial strobe merge
        wr(1, 5, 32'h11223344, 4'b0101);
        rd(1, 5, 32'hDE22BE44);

        // Same-bank collision stalls the read; different-bank pair proceeds together
        step(1'b1, mk_addr(0, 2), 32'h55667788, 4'hF, 1'b1, mk_addr(0, 2), 1'b0, 1'b0, 32'd0);
        rd(0, 2, 32'h55667788);
        step(1'b1, mk_addr(0, 3), 32'h01020304, 4'hF, 1'b1, mk_addr(1, 5), 1'b1, 1'b1, 32'hDE22BE44);
        rd(0, 3, 32'h01020304);

        // Zero strobe leaves the row untouched
        wr(0, 3, 32'hFFFFFFFF, 4'h0);
        rd(0, 3, 32'h01020304);

        // Back-to-back alternating bank reads
        wr(0, 7, 32'hA0A1A2A3, 4'hF);
        wr(1, 7, 32'hB0B1B2B3, 4'hF);
        wr(2, 7, 32'hC0C1C2C3, 4'hF);
        rd(0, 7, 32'hA0A1A2A3);
        rd(1, 7, 32'hB0B1B2B3);
        rd(0, 7, 32'hA0A1A2A3);
        rd(1, 7, 32'hB0B1B2B3);
        rd(2, 7, 32'hC0C1C2C3);
        idle(2);

        // Out-of-range bank: write dropped, read returns zero, err_oob pulses
        wr(3, 5, 32'hFFFFFFFF, 4'hF);
        idle(1);
        rd(1, 5, 32'hDE22BE44);
        rd(3, 5, 32'h00000000);
        idle(2);
        @(negedge clk);
        chk("oob_hold_zero", rsp_data, 32'h00000000);
        @(posedge clk);
        #1;

        // Read in flight when reset arrives yields no response; contents survive reset
        step(1'b0, 14'd0, 32'd0, 4'd0, 1'b1, mk_addr(1, 5), 1'b1, 1'b0, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("inflight_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_reset_rsp_data", rsp_data, 32'd0);
        chk("post_reset_err_oob", {31'd0, err_oob}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);
        rd(0, 3, 32'h01020304);
        rd(1, 5, 32'hDE22BE44);
        idle(4);

        chk("rsp_queue_drained", rsp_q.size(), 32'd0);
        chk("oob_queue_drained", oob_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
